seq_frac_mult: RTL

SEQ_FRAC_MULT -- requirements
Module: seq_frac_mult

---
 rtl/seq_frac_mult.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_frac_mult.sv
// ============================================================================
// Module   : seq_frac_mult
// Purpose  : Sequential signed fractional (Q1.(WORDLENGTH-1)) multiplier using
//            one unsigned shift-add iteration per clock, sign applied at the end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_frac_mult #(
  parameter int WORDLENGTH = 16
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORDLENGTH-1:0] multiplicand,
  input  logic [WORDLENGTH-1:0] multiplier,
  output logic [WORDLENGTH-1:0] product,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = WORDLENGTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_last_iter = CW'(W - 1);
  localparam logic [W-1:0]  c_max_pos   = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]    b_mag_q, b_mag_d;
  logic            sign_q, sign_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    a_mag, b_mag;
  logic [W-1:0]    trunc_mag;
  logic            saturate;

  // |0x8000| stays 0x8000 when read as unsigned
  assign a_mag = multiplicand[W-1] ? (~multiplicand + 1'b1) : multiplicand;
  assign b_mag = multiplier[W-1]   ? (~multiplier + 1'b1)   : multiplier;

  assign trunc_mag = acc_q[2*W-2:W-1];
  assign saturate  = |acc_q[2*W-1:2*W-2];

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_mag_d   = b_mag_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = {{W{1'b0}}, a_mag};
          b_mag_d = b_mag;
          sign_d  = multiplicand[W-1] ^ multiplier[W-1];
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (b_mag_q[0]) begin
          acc_d = acc_q + a_sh_q;
        end
        a_sh_d  = a_sh_q << 1;
        b_mag_d = b_mag_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == c_last_iter) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        // Negating a zero magnitude yields zero, so no negative zero can appear
        if (saturate) begin
          product_d = c_max_pos;
        end else if (sign_q) begin
          product_d = ~trunc_mag + 1'b1;
        end else begin
          product_d = trunc_mag;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_mag_q   <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_mag_q   <= b_mag_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire
